// File: rtl/huffman_pkg.sv
// Shared Huffman link constants: word width, symbol->code table, encoder FSM states.
// Codes are stored left-aligned in MAX_CODE_LEN bits, so the decoder LUT can share this table.
package huffman_pkg;

   localparam int WORD_W       = 10;
   localparam int MAX_CODE_LEN = 6;
   localparam int BUF_W        = 16;

   // Index is the symbol. A length of 0 marks an unmapped symbol (11 and 13).
   localparam logic [MAX_CODE_LEN-1:0] CODE_TABLE [16] = '{
      6'b100000,  // 0  : 1
      6'b010000,  // 1  : 0100
      6'b010100,  // 2  : 0101
      6'b011000,  // 3  : 011000
      6'b011001,  // 4  : 011001
      6'b001000,  // 5  : 0010
      6'b001100,  // 6  : 0011
      6'b011010,  // 7  : 01101
      6'b000110,  // 8  : 000110
      6'b011100,  // 9  : 0111
      6'b000000,  // 10 : 0000
      6'b000000,  // 11 : unmapped
      6'b000111,  // 12 : 000111
      6'b000000,  // 13 : unmapped
      6'b000100,  // 14 : 000100
      6'b000101   // 15 : 000101
   };

   localparam logic [2:0] LEN_TABLE [16] = '{
      3'd1, 3'd4, 3'd4, 3'd6, 3'd6, 3'd4, 3'd4, 3'd5,
      3'd6, 3'd4, 3'd4, 3'd0, 3'd6, 3'd0, 3'd6, 3'd6
   };

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/huffman_encoder_if.sv
// Symbol input, flush control and packed-word output of the Huffman encoder.
// master = symbol source / word sink, slave = encoder.
interface huffman_encoder_if;

   logic [3:0]                     sym_in;
   logic                           sym_valid;
   logic                           sym_ready;
   logic                           flush;
   logic                           flush_done;
   logic [huffman_pkg::WORD_W-1:0] enc_data;
   logic                           enc_valid;
   logic                           enc_ready;
   logic                           err_sym;

   modport master (
      output sym_in, sym_valid, flush, enc_ready,
      input  sym_ready, flush_done, enc_data, enc_valid, err_sym
   );

   modport slave (
      input  sym_in, sym_valid, flush, enc_ready,
      output sym_ready, flush_done, enc_data, enc_valid, err_sym
   );

endinterface

// File: rtl/huffman_code_lut.sv
// Combinational symbol -> left-aligned code / length lookup; valid is low for unmapped symbols.
module huffman_code_lut
   import huffman_pkg::*;
(
   input  logic [3:0]              sym,
   output logic [MAX_CODE_LEN-1:0] code,
   output logic [2:0]              len,
   output logic                    valid
);

   assign code  = CODE_TABLE[sym];
   assign len   = LEN_TABLE[sym];
   assign valid = (LEN_TABLE[sym] != 3'd0);

endmodule

// File: rtl/huffman_encoder.sv
// Huffman encoder: packs variable-length codes MSB-first into 10-bit words, with explicit flush.
// Optional symbol/bit statistics counters are enabled by defining HUFF_ENC_STATS_EN.
module huffman_encoder
   import huffman_pkg::*;
#(
   parameter logic PAD_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   huffman_encoder_if.slave bus
`ifdef HUFF_ENC_STATS_EN
   ,
   output logic [15:0]      sym_count,
   output logic [19:0]      bit_count
`endif
);

   localparam logic [4:0] WORD_FILL = 5'(WORD_W);

   state_t              state, state_nxt;
   logic [BUF_W-1:0]    bit_buf, bit_buf_nxt;
   logic [4:0]          fill, fill_nxt;
   logic [WORD_W-1:0]   enc_data_q, enc_data_nxt;
   logic                enc_valid_q, enc_valid_nxt;
   logic                sym_ready_q, sym_ready_nxt;
   logic                err_sym_q, err_sym_nxt;

   logic [MAX_CODE_LEN-1:0] lut_code;
   logic [2:0]              lut_len;
   logic                    lut_valid;
   logic                    accept;
   logic                    out_free;
   logic [BUF_W-1:0]        keep_mask;
   logic [WORD_W-1:0]       pad_word;

   huffman_code_lut u_lut (
      .sym   (bus.sym_in),
      .code  (lut_code),
      .len   (lut_len),
      .valid (lut_valid)
   );

   assign accept   = bus.sym_valid && sym_ready_q;
   assign out_free = !enc_valid_q || bus.enc_ready;

   // Unused low bits of bit_buf are always zero, so padding only has to OR in PAD_BIT.
   assign keep_mask = ~({BUF_W{1'b1}} >> fill);
   assign pad_word  = bit_buf[BUF_W-1 -: WORD_W]
                    | ({WORD_W{PAD_BIT}} & ~keep_mask[BUF_W-1 -: WORD_W]);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt     = state;
      bit_buf_nxt   = bit_buf;
      fill_nxt      = fill;
      enc_data_nxt  = enc_data_q;
      enc_valid_nxt = enc_valid_q;
      err_sym_nxt   = 1'b0;

      if (enc_valid_q && bus.enc_ready) enc_valid_nxt = 1'b0;

      // sym_ready implies fill<10, so accept and drain never collide.
      if (accept) begin
         if (lut_valid) begin
            bit_buf_nxt = bit_buf | ({lut_code, 10'b0} >> fill);
            fill_nxt    = fill + 5'(lut_len);
         end else begin
            err_sym_nxt = 1'b1;
         end
      end else if (fill >= WORD_FILL && out_free) begin
         enc_data_nxt  = bit_buf[BUF_W-1 -: WORD_W];
         enc_valid_nxt = 1'b1;
         bit_buf_nxt   = bit_buf << WORD_W;
         fill_nxt      = fill - WORD_FILL;
      end

      case (state)
         RUN: begin
            if (bus.flush) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (fill == 5'd0) begin
               state_nxt = DONE;
            end else if (fill < WORD_FILL && out_free) begin
               enc_data_nxt  = pad_word;
               enc_valid_nxt = 1'b1;
               bit_buf_nxt   = '0;
               fill_nxt      = 5'd0;
               state_nxt     = DONE;
            end
         end
         DONE: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase

      sym_ready_nxt = (state_nxt == RUN) && (fill_nxt < WORD_FILL);
   end

   // NOTE: sequential state uses non-blocking assignments only; the bit buffer is reset
   // too because a mid-stream reset must discard every buffered bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RUN;
         bit_buf     <= '0;
         fill        <= 5'd0;
         enc_data_q  <= '0;
         enc_valid_q <= 1'b0;
         sym_ready_q <= 1'b0;
         err_sym_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_buf     <= bit_buf_nxt;
         fill        <= fill_nxt;
         enc_data_q  <= enc_data_nxt;
         enc_valid_q <= enc_valid_nxt;
         sym_ready_q <= sym_ready_nxt;
         err_sym_q   <= err_sym_nxt;
      end
   end

   assign bus.enc_data   = enc_data_q;
   assign bus.enc_valid  = enc_valid_q;
   assign bus.sym_ready  = sym_ready_q;
   assign bus.err_sym    = err_sym_q;
   assign bus.flush_done = (state == DONE);

`ifdef HUFF_ENC_STATS_EN
   // Counters wrap naturally and survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sym_count <= '0;
         bit_count <= '0;
      end else if (accept) begin
         sym_count <= sym_count + 16'd1;
         if (lut_valid) bit_count <= bit_count + 20'(lut_len);
      end
   end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder: bit-level packing model feeds a scoreboard of expected words.
module tb_huffman_encoder;

   logic clk;
   logic rst;
   huffman_encoder_if bus ();

`ifdef HUFF_ENC_STATS_EN
   logic [15:0] sym_count;
   logic [19:0] bit_count;
`endif

   huffman_encoder #(.PAD_BIT(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef HUFF_ENC_STATS_EN
      ,
      .sym_count (sym_count),
      .bit_count (bit_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          word_cnt = 0;
   int          err_cnt = 0;
   int          tb_syms = 0;
   int          tb_bits = 0;
   logic [9:0]  last_word = '0;
   logic        mbits[$];
   logic [9:0]  exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference codes, right-aligned, written straight from the code table.
   task automatic model_push(input logic [3:0] s);
      logic [5:0] c;
      int         l;
      logic [9:0] w;
      case (s)
         4'd0:  begin c = 6'b000001; l = 1; end
         4'd1:  begin c = 6'b000100; l = 4; end
         4'd2:  begin c = 6'b000101; l = 4; end
         4'd3:  begin c = 6'b011000; l = 6; end
         4'd4:  begin c = 6'b011001; l = 6; end
         4'd5:  begin c = 6'b000010; l = 4; end
         4'd6:  begin c = 6'b000011; l = 4; end
         4'd7:  begin c = 6'b001101; l = 5; end
         4'd8:  begin c = 6'b000110; l = 6; end
         4'd9:  begin c = 6'b000111; l = 4; end
         4'd10: begin c = 6'b000000; l = 4; end
         4'd12: begin c = 6'b000111; l = 6; end
         4'd14: begin c = 6'b000100; l = 6; end
         4'd15: begin c = 6'b000101; l = 6; end
         default: begin c = 6'b000000; l = 0; end
      endcase
      tb_syms++;
      tb_bits += l;
      for (int i = l - 1; i >= 0; i--) mbits.push_back(c[i]);
      while (mbits.size() >= 10) begin
         for (int i = 9; i >= 0; i--) w[i] = mbits.pop_front();
         exp_q.push_back(w);
      end
   endtask

   task automatic model_flush();
      logic [9:0] w;
      if (mbits.size() > 0) begin
         for (int i = 9; i >= 0; i--) w[i] = (mbits.size() > 0) ? mbits.pop_front() : 1'b0;
         exp_q.push_back(w);
      end
   endtask

   // Scoreboard: every word taken by the sink must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst && bus.enc_valid && bus.enc_ready) begin
         word_cnt++;
         last_word = bus.enc_data;
         if (exp_q.size() == 0) check("unexpected_word", 32'(bus.enc_data), 32'h3ff_ffff);
         else check("word", 32'(bus.enc_data), 32'(exp_q.pop_front()));
      end
      if (rst && bus.err_sym) err_cnt++;
   end

   task automatic send(input logic [3:0] s, input logic with_flush);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.sym_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", 32'(bus.sym_ready), 32'd1);
      bus.sym_in    = s;
      bus.sym_valid = 1'b1;
      bus.flush     = with_flush;
      @(posedge clk);
      #1;
      bus.sym_valid = 1'b0;
      bus.flush     = 1'b0;
      model_push(s);
      if (with_flush) model_flush();
   endtask

   task automatic wait_flush_done(output logic v_at_done, output logic [9:0] d_at_done);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.flush_done && n < 100);
      check("flush_done_seen", 32'(bus.flush_done), 32'd1);
      v_at_done = bus.enc_valid;
      d_at_done = bus.enc_data;
      @(negedge clk);
      check("flush_done_one_cycle", 32'(bus.flush_done), 32'd0);
   endtask

   task automatic do_flush(output logic v_at_done, output logic [9:0] d_at_done);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      model_flush();
      wait_flush_done(v_at_done, d_at_done);
   endtask

   task automatic drain_wait(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         wc0;
      logic       v_done;
      logic [9:0] d_done;

      rst           = 1'b0;
      bus.sym_in    = '0;
      bus.sym_valid = 1'b0;
      bus.flush     = 1'b0;
      bus.enc_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_sym_ready", 32'(bus.sym_ready), 32'd0);
      check("rst_enc_valid", 32'(bus.enc_valid), 32'd0);
      check("rst_enc_data", 32'(bus.enc_data), 32'd0);
      check("rst_flush_done", 32'(bus.flush_done), 32'd0);
      check("rst_err_sym", 32'(bus.err_sym), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.sym_ready), 32'd1);

      // Ten symbol 0 -> one all-ones word, sym_ready low only for the drain cycle
      for (int i = 0; i < 10; i++) send(4'd0, 1'b0);
      @(negedge clk);
      check("t1_ready_low", 32'(bus.sym_ready), 32'd0);
      check("t1_valid_pre", 32'(bus.enc_valid), 32'd0);
      @(negedge clk);
      check("t1_ready_back", 32'(bus.sym_ready), 32'd1);
      check("t1_valid", 32'(bus.enc_valid), 32'd1);
      check("t1_data", 32'(bus.enc_data), 32'h3ff);
      @(negedge clk);
      check("t1_valid_one_cycle", 32'(bus.enc_valid), 32'd0);
      check("t1_words", word_cnt, 1);

      // 9,2,0,0 -> exactly one word, nothing left over
      send(4'd9, 1'b0);
      send(4'd2, 1'b0);
      send(4'd0, 1'b0);
      send(4'd0, 1'b0);
      drain_wait("t2_drain");
      check("t2_data", 32'(last_word), 32'(10'b0111010111));
      wc0 = word_cnt;
      do_flush(v_done, d_done);
      check("t2_empty_flush_no_word", word_cnt, wc0);

      // 3,3 then flush -> one full word plus a padded word
      wc0 = word_cnt;
      send(4'd3, 1'b0);
      send(4'd3, 1'b0);
      do_flush(v_done, d_done);
      drain_wait("t3_drain");
      check("t3_words", word_cnt - wc0, 2);
      check("t3_valid_at_done", 32'(v_done), 32'd1);
      check("t3_pad_word", 32'(d_done), 32'd0);

      // 20 symbol 0 with the sink stalled: first word held, input stalls, no bits lost
      wc0 = word_cnt;
      bus.enc_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) send(4'd0, 1'b0);
         end
         begin
            for (int c = 0; c < 25; c++) begin
               @(negedge clk);
               if (bus.enc_valid) check("t4_hold", 32'(bus.enc_data), 32'h3ff);
            end
            check("t4_stall_ready", 32'(bus.sym_ready), 32'd0);
            check("t4_stall_valid", 32'(bus.enc_valid), 32'd1);
            bus.enc_ready = 1'b1;
         end
      join
      drain_wait("t4_drain");
      check("t4_words", word_cnt - wc0, 2);

      // Unmapped 11 and 13 flag errors and add no bits; then 7 with flush in the same cycle
      wc0 = err_cnt;
      send(4'd11, 1'b0);
      send(4'd13, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("t5_err_pulses", err_cnt - wc0, 2);
      wc0 = word_cnt;
      send(4'd7, 1'b1);
      wait_flush_done(v_done, d_done);
      drain_wait("t5_drain");
      check("t5_words", word_cnt - wc0, 1);
      check("t5_data", 32'(last_word), 32'(10'b0110100000));
`ifdef HUFF_ENC_STATS_EN
      check("stats_sym_count", 32'(sym_count), 32'(tb_syms));
      check("stats_bit_count", 32'(bit_count), 32'(tb_bits));
`endif

      // Reset with 7 bits buffered discards them
      for (int i = 0; i < 7; i++) send(4'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      mbits.delete();
      @(negedge clk);
      check("t6_rst_sym_ready", 32'(bus.sym_ready), 32'd0);
      check("t6_rst_enc_valid", 32'(bus.enc_valid), 32'd0);
      check("t6_rst_enc_data", 32'(bus.enc_data), 32'd0);
      check("t6_rst_flush_done", 32'(bus.flush_done), 32'd0);
      check("t6_rst_err_sym", 32'(bus.err_sym), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      wc0 = word_cnt;
      do_flush(v_done, d_done);
      repeat (3) @(negedge clk);
      check("t6_flush_no_word", word_cnt, wc0);
`ifdef HUFF_ENC_STATS_EN
      check("stats_cleared", 32'(sym_count), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
